// File: rtl/mf_pkg.sv
// Shared definitions for the MF gvector accumulator: default widths,
// the controller state encoding and the block-size helper.
package mf_pkg;

    localparam int DW_DEF   = 8;   // sample width
    localparam int AW_DEF   = 8;   // MF address width
    localparam int SUMW_DEF = 24;  // holds 255*255*255 without overflow
    localparam int CNTW     = 16;  // sample counter / block size width
    localparam int DIMW     = 8;   // height/width port width

    // Running-minimum start value; sliced to the sample width where used.
    localparam logic [63:0] MIN_INIT = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of samples in an h x w block; 255*255 = 65025 fits in 16 bits.
    function automatic logic [CNTW-1:0] block_size(input logic [DIMW-1:0] h,
                                                   input logic [DIMW-1:0] w);
        return CNTW'(h) * CNTW'(w);
    endfunction

endpackage

// File: rtl/mf_stat_acc.sv
// Per-block statistics registers: running sum, min, max and sample count.
// The count saturates at the block size, and o_last flags the sample that
// completes the block so the controller can close it.
module mf_stat_acc
    import mf_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int SUMW = SUMW_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_empty,
    input  logic            i_accept,
    input  logic [DW-1:0]   i_data,
    input  logic [CNTW-1:0] i_limit,
    output logic            o_last,
    output logic [SUMW-1:0] o_sum,
    output logic [DW-1:0]   o_min,
    output logic [DW-1:0]   o_max,
    output logic [CNTW-1:0] o_cnt
);

    logic [SUMW-1:0] r_sum;
    logic [DW-1:0]   r_min;
    logic [DW-1:0]   r_max;
    logic [CNTW-1:0] r_cnt;

    logic            w_take;
    logic [CNTW:0]   w_cnt_inc;

    // Qualify acceptance against saturation and detect the block-closing sample.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_take    = i_accept && (r_cnt != i_limit);
        w_cnt_inc = {1'b0, r_cnt} + (CNTW+1)'(1);
        o_last    = w_take && (w_cnt_inc == {1'b0, i_limit});
    end

    // Clear at block start, otherwise fold each accepted sample into the stats.
    // NOTE: reset is synchronous and active-low, so it only acts on a clock edge.
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sum <= '0;
            r_min <= '0;
            r_max <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
            r_max <= '0;
            r_cnt <= '0;
            // An empty block reports min = 0 rather than the search start value.
            r_min <= i_empty ? '0 : MIN_INIT[DW-1:0];
        end else if (w_take) begin
            r_sum <= r_sum + SUMW'(i_data);
            if (i_data < r_min) r_min <= i_data;
            if (i_data > r_max) r_max <= i_data;
            r_cnt <= w_cnt_inc[CNTW-1:0];
        end
    end

    assign o_sum = r_sum;
    assign o_min = r_min;
    assign o_max = r_max;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/mf_gvector_accum.sv
// Downstream consumer of the MF address/data generator. Requests a block,
// collects height x width samples, and presents sum/min/max/count plus the
// block origin through a valid/ack handshake. New requests are held off
// until the previous result has been acknowledged.
module mf_gvector_accum
    import mf_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF,
    parameter int SUMW = SUMW_DEF
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            enable,
    input  logic [7:0]      height,
    input  logic [7:0]      width,
    input  logic [AW-1:0]   addr_x0,
    input  logic [AW-1:0]   addr_y0,
    input  logic [DW-1:0]   gdata,
    input  logic            Gvector_sig,
    output logic            Nxt_block_sig,
    output logic            res_valid,
    input  logic            res_ack,
    output logic [SUMW-1:0] blk_sum,
    output logic [DW-1:0]   blk_min,
    output logic [DW-1:0]   blk_max,
    output logic [15:0]     blk_cnt,
    output logic [AW-1:0]   blk_x0,
    output logic [AW-1:0]   blk_y0,
    output logic            ovf
);

    state_t          r_state;
    state_t          w_state_nxt;

    logic [CNTW-1:0] r_n;
    logic [AW-1:0]   r_x0;
    logic [AW-1:0]   r_y0;
    logic            r_ovf;

    logic            w_latch;
    logic            w_accept;
    logic            w_clear;
    logic            w_empty;
    logic            w_last;
    logic [CNTW-1:0] w_cnt;

    // Block geometry is captured only when leaving IDLE or when an acked
    // result chains straight into the next request.
    assign w_latch  = enable && ((r_state == IDLE) || ((r_state == DONE) && res_ack));
    assign w_accept = (r_state == ACCUM) && Gvector_sig && enable;
    assign w_clear  = (r_state == REQ);
    assign w_empty  = (r_n == '0);

    mf_stat_acc #(
        .DW   (DW),
        .SUMW (SUMW)
    ) u_stat (
        .i_clk    (CLK),
        .i_rst_n  (reset),
        .i_clear  (w_clear),
        .i_empty  (w_empty),
        .i_accept (w_accept),
        .i_data   (gdata),
        .i_limit  (r_n),
        .o_last   (w_last),
        .o_sum    (blk_sum),
        .o_min    (blk_min),
        .o_max    (blk_max),
        .o_cnt    (w_cnt)
    );

    assign blk_cnt = w_cnt;

    // State register; reset in any state abandons the block in progress.
    always_ff @(posedge CLK) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: request, accumulate, then hold the result until acked.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = REQ;
            REQ:     w_state_nxt = w_empty ? DONE : ACCUM;
            ACCUM:   if (w_last) w_state_nxt = DONE;
            DONE:    if (res_ack) w_state_nxt = enable ? REQ : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Moore outputs: request pulse in REQ, result valid for the whole of DONE.
    always_comb begin
        Nxt_block_sig = (r_state == REQ);
        res_valid     = (r_state == DONE);
    end

    // Capture the block size at each latch point; later height/width edits are ignored.
    always_ff @(posedge CLK) begin
        if (!reset)       r_n <= '0;
        else if (w_latch) r_n <= block_size(height, width);
    end

    // Block origin comes from the first accepted sample; cleared at each request.
    always_ff @(posedge CLK) begin
        if (!reset || w_clear) begin
            r_x0 <= '0;
            r_y0 <= '0;
        end else if (w_accept && (w_cnt == '0)) begin
            r_x0 <= addr_x0;
            r_y0 <= addr_y0;
        end
    end

    assign blk_x0 = r_x0;
    assign blk_y0 = r_y0;

    // Sticky flag for samples offered while no block is open.
    always_ff @(posedge CLK) begin
        if (!reset)                                   r_ovf <= 1'b0;
        else if (Gvector_sig && (r_state != ACCUM))   r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;

endmodule
